// File: rtl/fetch_pkg.sv
// Shared types for the fetch controller slice.
// Instruction/address widths, FSM states and the default boot PC.
package fetch_pkg;

  typedef logic [18:0] instr_t;
  typedef logic [11:0] addr_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  localparam addr_t RESET_PC_DEFAULT = 12'h000;

endpackage

// File: rtl/fetch_controller_if.sv
// Memory read port plus decoder valid/ready handshake.
// The controller is the master side; memory and decoder are the slave.
interface fetch_controller_if;
  import fetch_pkg::*;

  addr_t  imem_addr;
  instr_t imem_instr;
  instr_t instr_out;
  addr_t  pc_out;
  logic   instr_valid;
  logic   instr_ready;

  modport master (
    output imem_addr,
    output instr_out,
    output pc_out,
    output instr_valid,
    input  imem_instr,
    input  instr_ready
  );

  modport slave (
    input  imem_addr,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output imem_instr,
    output instr_ready
  );

endinterface

// File: rtl/return_stack.sv
// Return-address stack: push/pop with full/empty flags.
// Push wins over pop; overflow and underflow requests are dropped.
module return_stack
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  addr_t din,
  output addr_t top,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  addr_t         mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = cnt[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign full    = (cnt == CAP);
  assign empty   = (cnt == '0);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + ONE;
    end else if (pop && !empty) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: boot/run/halt FSM, PC sequencing, redirects.
// Define FETCH_RAS_EN to build the return-address stack for call/ret.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC  = RESET_PC_DEFAULT,
  parameter int    RAS_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  fetch_controller_if.master bus,
  input  logic  redirect_valid,
  input  addr_t redirect_addr,
  input  logic  call_valid,
  input  addr_t call_addr,
  input  logic  ret_valid,
  input  logic  halt,
  input  logic  resume,
  output logic  ras_err,
  output logic  running
);

  state_t state;
  addr_t  pc;
  addr_t  tgt;
  addr_t  ras_top;
  logic   ras_full;
  logic   ras_empty;
  logic   ret_en;
  logic   live;
  logic   sel_redir;
  logic   sel_call;
  logic   sel_ret;
  logic   ev;
  logic   err_set;

  assign bus.imem_addr = pc;
  assign running = (state == S_RUN);
  assign live = (state == S_RUN) && !halt;

  assign sel_redir = redirect_valid;
  assign sel_call  = call_valid && !redirect_valid;
  assign sel_ret   = ret_en && !call_valid && !redirect_valid;

`ifdef FETCH_RAS_EN
  logic push;
  logic pop;

  assign ret_en = ret_valid;
  assign push = live && sel_call && !ras_full;
  assign pop  = live && sel_ret && !ras_empty;

  return_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc_out + 12'd1),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );
`else
  assign ret_en    = ret_valid & 1'b0;
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
`endif

  // An empty-stack ret targets the current pc: a bubble, not a jump.
  always_comb begin
    ev      = sel_redir || sel_call || sel_ret;
    tgt     = pc;
    err_set = 1'b0;
    unique case (1'b1)
      sel_redir: tgt = redirect_addr;
      sel_call: begin
        tgt     = call_addr;
        err_set = ras_full;
      end
      sel_ret: begin
        tgt     = ras_empty ? pc : ras_top;
        err_set = ras_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_BOOT;
      pc              <= RESET_PC;
      bus.instr_out   <= '0;
      bus.pc_out      <= '0;
      bus.instr_valid <= 1'b0;
      ras_err         <= 1'b0;
    end else begin
      unique case (state)
        S_BOOT: state <= S_RUN;
        S_HALT: begin
          if (resume && !halt) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (halt) begin
            state           <= S_HALT;
            bus.instr_valid <= 1'b0;
            // Refetch a stalled word so it is not lost across halt.
            if (bus.instr_valid && !bus.instr_ready) begin
              pc <= bus.pc_out;
            end
          end else if (ev) begin
            pc              <= tgt;
            bus.instr_valid <= 1'b0;
            if (err_set) begin
              ras_err <= 1'b1;
            end
          end else if (!bus.instr_valid || bus.instr_ready) begin
            bus.instr_out   <= bus.imem_instr;
            bus.pc_out      <= pc;
            bus.instr_valid <= 1'b1;
            pc              <= pc + 12'd1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule
